alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the team's combinational ALU.
- Registers operands and flags behind a valid/ready handshake on both sides.
- Adds OR and an iterative shift-add multiply; an iterative divide can be compiled in.
- Sits between the execute-stage issue logic and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from B (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- opcode  in  3  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  registered result.
- carry  out  1  carry / borrow / high-part-nonzero flag.
- zero  out  1  result == 0.
- negative  out  1  result[WIDTH-1].
- overflow  out  1  signed overflow.
- busy  out  1  iterative operation in progress.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; result=0; all flags=0; out_valid=0; busy=0; in_ready=1 after reset release. Reset mid-operation discards the operation; no partial result is presented.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Accept on in_valid & in_ready; latch opcode, a and b.
  - Single-cycle op: go to DONE with result registered, so out_valid rises 1 cycle after accept.
  - MUL or DIVU: go to BUSY with iteration counter=0.
  - BUSY: one iteration per cycle; after WIDTH iterations go to DONE. out_valid rises WIDTH+1 cycles after accept. busy=1 only in BUSY.
  - DONE: out_valid=1. result and flags are held stable until out_ready=1, then go to IDLE. in_ready=0 in BUSY and DONE; no accept while a result is pending.
- Opcodes, all unsigned modulo 2^WIDTH unless stated:
  - 000 ADD: a+b. carry=bit WIDTH of the (WIDTH+1)-bit sum. overflow=(a,b same sign) & (result sign differs).
  - 001 SUB: a-b. carry=borrow=(b>a unsigned). overflow=(a,b signs differ) & (result sign != a sign).
  - 010 AND: a&b. carry=overflow=0.
  - 011 SLL: a << b[SHW-1:0]. Upper bits of b are ignored. carry=overflow=0.
  - 100 SRL: a >> b[SHW-1:0], logical (zero fill). carry=overflow=0.
  - 101 OR: a|b. carry=overflow=0.
  - 110 MUL: unsigned shift-add, one multiplier bit per BUSY cycle. result=low WIDTH bits of the product. carry=1 if the high WIDTH bits are nonzero. overflow=0.
  - 111: see Optional Feature.
- zero and negative are always derived from the final registered result, for every opcode including 111.
- Inputs a/b/opcode may change after acceptance without effect.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: opcode 111 = DIVU, a restoring unsigned divide. One quotient bit per BUSY cycle, WIDTH cycles. result=quotient; carry=0; overflow=0.
  - b==0: result = all ones; carry=1; overflow=0. Still takes WIDTH BUSY cycles.
- Undefined: opcode 111 completes as a single-cycle op. result=0, zero=1, carry=overflow=negative=0. No divider logic is synthesised.

Test Plan (WIDTH=32):
- ADD carry/overflow: a=0x7FFFFFFF, b=1 -> 1 cycle after accept: result=0x80000000, overflow=1, negative=1, carry=0. Then a=0xFFFFFFFF, b=1 -> result=0, carry=1, zero=1, overflow=0.
- SUB borrow and shift masking: SUB a=3, b=5 -> result=0xFFFFFFFE, carry=1, negative=1. SLL a=1, b=0x21 -> result=2 (only b[4:0]=1 used).
- MUL latency and handshake: a=0x10000, b=0x10000 -> in_ready=0 and busy=1 for 32 cycles; out_valid rises exactly 33 cycles after accept; result=0, carry=1, zero=1. Holding out_ready=0 for 5 cycles keeps result and flags stable; in_ready returns 1 one cycle after out_ready=1.
- Back-pressure: in_valid held high with a new op while DONE and out_ready=0 -> not accepted; it is accepted only after the pending result drains.
- Reset mid-MUL: assert rst_n=0 at iteration 10 -> out_valid, busy, result and flags all 0 immediately (asynchronous). After release, in_ready=1, and the next ADD 2+2 gives result=4.
- Opcode 111, a=100, b=0:
  - With ALU_MC_DIV_EN: result=0xFFFFFFFF, carry=1, after 33 cycles. Also a=100, b=7 -> result=14.
  - Without ALU_MC_DIV_EN: result=0, zero=1, after 1 cycle.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes on input and output.
// Single-cycle ops (ADD, SUB, AND, SLL, SRL, OR) finish one cycle after accept.
// MUL is an iterative shift-add multiply: one multiplier bit per BUSY cycle.
// Define ALU_MC_DIV_EN to build opcode 111 as an iterative restoring unsigned
// divide; without it, opcode 111 is a single-cycle op returning zero.
// Only one operation is in flight at a time.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_DIV = 3'b111;

    localparam logic [SHW-1:0] LAST_ITER = SHW'(WIDTH - 1);

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [2:0]       op;
    // opa holds the multiplicand (MUL) or divisor (DIVU).
    // hi/lo hold partial product (MUL) or remainder/quotient (DIVU).
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Single-cycle datapath operates directly on the handshake inputs.
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   dif_w;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry;
    logic             sc_ovf;
    logic             is_iter;

    // Iteration step and final result of an iterative op.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    logic [WIDTH-1:0] fin_res;
    logic             fin_carry;

    assign sum_w   = {1'b0, a} + {1'b0, b};
    assign dif_w   = {1'b0, a} - {1'b0, b};
    assign mul_sum = {1'b0, hi} + ({1'b0, opa} & {(WIDTH + 1){lo[0]}});

`ifdef ALU_MC_DIV_EN
    assign is_iter = (opcode == OP_MUL) || (opcode == OP_DIV);

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             div_ge;

    // A zero divisor always "fits", which yields an all-ones quotient.
    assign div_shift = {hi, lo[WIDTH-1]};
    assign div_trial = div_shift - {1'b0, opa};
    assign div_ge    = (opa == '0) || !div_trial[WIDTH];
`else
    assign is_iter = (opcode == OP_MUL);
`endif

    // Single-cycle result and carry/overflow flags from the raw inputs.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case statement can infer a latch.
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (opcode)
            OP_ADD: begin
                sc_res   = sum_w[WIDTH-1:0];
                sc_carry = sum_w[WIDTH];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res   = dif_w[WIDTH-1:0];
                sc_carry = dif_w[WIDTH];
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_res = a & b;
            OP_SLL:  sc_res = a << b[SHW-1:0];
            OP_SRL:  sc_res = a >> b[SHW-1:0];
            OP_OR:   sc_res = a | b;
            default: sc_res = '0;
        endcase
    end

    // One multiply or divide iteration, plus the result taken on the last one.
    always_comb begin
        step_hi   = mul_sum[WIDTH:1];
        step_lo   = {mul_sum[0], lo[WIDTH-1:1]};
        fin_res   = step_lo;
        fin_carry = (step_hi != '0);
`ifdef ALU_MC_DIV_EN
        if (op == OP_DIV) begin
            step_hi   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo   = {lo[WIDTH-2:0], div_ge};
            fin_res   = step_lo;
            fin_carry = (opa == '0);
        end
`endif
    end

    // Control FSM with registered handshake, status, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset along with the control
            // state so that no X from a discarded operation can ever leak out.
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            cnt       <= '0;
            op        <= OP_ADD;
            opa       <= '0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the pre-edge values regardless of statement order.
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (is_iter) begin
                            state <= BUSY;
                            busy  <= 1'b1;
                            op    <= opcode;
                            opa   <= (opcode == OP_MUL) ? a : b;
                            lo    <= (opcode == OP_MUL) ? b : a;
                            hi    <= '0;
                            cnt   <= '0;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= sc_res;
                            carry     <= sc_carry;
                            overflow  <= sc_ovf;
                            zero      <= (sc_res == '0);
                            negative  <= sc_res[WIDTH-1];
                        end
                    end
                end
                BUSY: begin
                    hi  <= step_hi;
                    lo  <= step_lo;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        result    <= fin_res;
                        carry     <= fin_carry;
                        overflow  <= 1'b0;
                        zero      <= (fin_res == '0);
                        negative  <= fin_res[WIDTH-1];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=32.
// Flags are compared as the vector {carry, zero, negative, overflow}.
module tb_alu_mc;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    opcode;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carry;
    logic          zero;
    logic          negative;
    logic          overflow;
    logic          busy;

    int checks = 0;
    int errors = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] flags();
        return {carry, zero, negative, overflow};
    endfunction

    // Present one op for exactly one clock edge, then scramble the inputs.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        opcode   = op;
        a        = x;
        b        = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        opcode   = 3'b010;
        a        = 32'hDEAD_BEEF;
        b        = 32'h1234_5678;
    endtask

    // Latency in cycles from accept to out_valid (1 = next cycle); -1 on timeout.
    task automatic wait_result(output int lat);
        lat = -1;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                lat = k + 1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        opcode = '0; a = '0; b = '0;
        #2;
        checks++;
        if ({out_valid, busy, flags()} !== 6'b0) begin
            errors++;
            $display("FAIL reset_status: got ov/busy/flags=%b expected 000000", {out_valid, busy, flags()});
        end
        checks++;
        if (result !== 32'h0) begin
            errors++;
            $display("FAIL reset_result: got %h expected 00000000", result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        issue(3'b000, 32'h7FFF_FFFF, 32'h1);
        wait_result(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL add_latency: got %0d expected 1", lat);
        end
        checks++;
        if (result !== 32'h8000_0000 || flags() !== 4'b0011) begin
            errors++;
            $display("FAIL add_ovf: got %h cznv=%b expected 80000000 cznv=0011", result, flags());
        end
        drain();
        issue(3'b000, 32'hFFFF_FFFF, 32'h1);
        wait_result(lat);
        checks++;
        if (lat !== 1 || result !== 32'h0 || flags() !== 4'b1100) begin
            errors++;
            $display("FAIL add_carry: got lat=%0d %h cznv=%b expected lat=1 00000000 cznv=1100", lat, result, flags());
        end
        drain();
    endtask

    task automatic test_logic_shift();
        int lat;
        logic [2:0]   ops  [5] = '{3'b001, 3'b011, 3'b100, 3'b010, 3'b101};
        logic [W-1:0] va   [5] = '{32'd3, 32'd1, 32'h8000_0000, 32'h0000_F0F0, 32'h0000_F0F0};
        logic [W-1:0] vb   [5] = '{32'd5, 32'h21, 32'h24, 32'h0000_0FF0, 32'h0000_0FF0};
        logic [W-1:0] vres [5] = '{32'hFFFF_FFFE, 32'd2, 32'h0800_0000, 32'h0000_00F0, 32'h0000_FFF0};
        logic [3:0]   vfl  [5] = '{4'b1010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], va[i], vb[i]);
            wait_result(lat);
            checks++;
            if (lat !== 1 || result !== vres[i] || flags() !== vfl[i]) begin
                errors++;
                $display("FAIL op%b_vec%0d: got lat=%0d %h cznv=%b expected lat=1 %h cznv=%b",
                         ops[i], i, lat, result, flags(), vres[i], vfl[i]);
            end
            drain();
        end
    endtask

    task automatic test_mul();
        int lat;
        int busy_cycles;
        int stall_bad;
        issue(3'b110, 32'h0001_0000, 32'h0001_0000);
        lat = -1; busy_cycles = 0; stall_bad = 0;
        for (int k = 0; k < 100; k++) begin
            if (out_valid) begin
                lat = k + 1;
                break;
            end
            if (busy) busy_cycles++;
            if (in_ready !== 1'b0) stall_bad++;
            @(posedge clk); #1;
        end
        checks++;
        if (lat !== 33 || busy_cycles !== 32 || stall_bad !== 0) begin
            errors++;
            $display("FAIL mul_timing: got lat=%0d busy=%0d in_ready_hi=%0d expected 33 32 0", lat, busy_cycles, stall_bad);
        end
        checks++;
        if (result !== 32'h0 || flags() !== 4'b1100 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_result: got %h cznv=%b busy=%b expected 00000000 cznv=1100 busy=0", result, flags(), busy);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || result !== 32'h0 || flags() !== 4'b1100) begin
                errors++;
                $display("FAIL mul_hold%0d: got ov/ir=%b %h cznv=%b expected 10 00000000 1100",
                         k, {out_valid, in_ready}, result, flags());
            end
        end
        drain();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL mul_drain: got ov/ir=%b expected 01", {out_valid, in_ready});
        end
        issue(3'b110, 32'h0000_FFFF, 32'h0000_FFFF);
        wait_result(lat);
        checks++;
        if (lat !== 33 || result !== 32'hFFFE_0001 || flags() !== 4'b0010) begin
            errors++;
            $display("FAIL mul_ffff: got lat=%0d %h cznv=%b expected 33 fffe0001 0010", lat, result, flags());
        end
        drain();
        issue(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_result(lat);
        checks++;
        if (lat !== 33 || result !== 32'h1 || flags() !== 4'b1000) begin
            errors++;
            $display("FAIL mul_max: got lat=%0d %h cznv=%b expected 33 00000001 1000", lat, result, flags());
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(3'b000, 32'd1, 32'd2);
        in_valid = 1'b1; opcode = 3'b000; a = 32'd10; b = 32'd20;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready} !== 2'b10 || result !== 32'd3) begin
                errors++;
                $display("FAIL bp_hold%0d: got ov/ir=%b %h expected 10 00000003", k, {out_valid, in_ready}, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01 || result !== 32'd3) begin
            errors++;
            $display("FAIL bp_drain: got ov/ir=%b %h expected 01 00000003", {out_valid, in_ready}, result);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_result(lat);
        checks++;
        if (lat !== 1 || result !== 32'd30) begin
            errors++;
            $display("FAIL bp_accept: got lat=%0d %h expected 1 0000001e", lat, result);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        issue(3'b110, 32'h0001_0000, 32'h0001_0000);
        repeat (9) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, busy, flags()} !== 6'b0 || result !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: got ov/busy/flags=%b %h expected 000000 00000000", {out_valid, busy, flags()}, result);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rst_release: got ir/ov/busy=%b expected 100", {in_ready, out_valid, busy});
        end
        issue(3'b000, 32'd2, 32'd2);
        wait_result(lat);
        checks++;
        if (lat !== 1 || result !== 32'd4 || flags() !== 4'b0000) begin
            errors++;
            $display("FAIL rst_add: got lat=%0d %h cznv=%b expected 1 00000004 0000", lat, result, flags());
        end
        drain();
    endtask

    task automatic test_op7();
        int lat;
        issue(3'b111, 32'd100, 32'd0);
        wait_result(lat);
`ifdef ALU_MC_DIV_EN
        checks++;
        if (lat !== 33 || result !== 32'hFFFF_FFFF || flags() !== 4'b1010) begin
            errors++;
            $display("FAIL div_by0: got lat=%0d %h cznv=%b expected 33 ffffffff 1010", lat, result, flags());
        end
        drain();
        issue(3'b111, 32'd100, 32'd7);
        wait_result(lat);
        checks++;
        if (lat !== 33 || result !== 32'd14 || flags() !== 4'b0000) begin
            errors++;
            $display("FAIL div_7: got lat=%0d %h cznv=%b expected 33 0000000e 0000", lat, result, flags());
        end
`else
        checks++;
        if (lat !== 1 || result !== 32'h0 || flags() !== 4'b0100) begin
            errors++;
            $display("FAIL op7_nodiv: got lat=%0d %h cznv=%b expected 1 00000000 0100", lat, result, flags());
        end
`endif
        drain();
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic_shift();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        test_op7();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
